// File: rtl/instr_fetch_seq.sv
// Purpose : instruction fetch sequencer. It holds the PC and IR, issues imem reads and computes the next PC.
// Latency : 1 cycle from the first imem_req cycle to instr_valid. The next fetch starts on the edge after exec_done.
// Backpressure: imem_req and imem_addr are held stable until imem_ack. EXEC is held until exec_done.
//
// Ports:
//   clk, rst            - clock; synchronous active-high reset
//   NPCOp, IMM          - next-PC select (00/11 PLUS4, 01 BRANCH, 10 JUMP) and immediate field
//   exec_done           - core finished current instruction (sampled in EXEC only)
//   imem_req/addr/ack/rdata - instruction memory read handshake
//   instr, Op, Funct    - instruction register and its opcode/function slices
//   instr_valid         - IR holds the instruction at PC
//   PC                  - current program counter
//   fetch_err           - sticky fetch timeout flag
// Optional feature: define FETCH_TIMEOUT_EN to enable the 16-cycle fetch timeout and the HALT state.
module instr_fetch_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  NPCOp,
  input  logic [25:0] IMM,
  input  logic        exec_done,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  Op,
  output logic [5:0]  Funct,
  output logic        instr_valid,
  output logic [31:0] PC,
  output logic        fetch_err
);

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_q, ir_q;
  logic        pc_ld, ir_ld;
  logic [31:0] pc4, npc;

`ifdef FETCH_TIMEOUT_EN
  logic [4:0]  tmo_cnt, tmo_cnt_nxt;
  logic        err_q, err_set;
`endif

  // Next-PC arithmetic; all sums wrap modulo 2^32.
  always_comb begin
    pc4 = pc_q + 32'd4;
    case (NPCOp)
      2'b01:   npc = pc4 + {{14{IMM[15]}}, IMM[15:0], 2'b00};
      2'b10:   npc = {pc4[31:28], IMM, 2'b00};
      default: npc = pc4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc_q  <= RESET_PC;
      ir_q  <= 32'h0000_0000;
    end else begin
      state <= state_nxt;
      if (pc_ld) pc_q <= npc;
      if (ir_ld) ir_q <= imem_rdata;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= 5'd0;
      err_q   <= 1'b0;
    end else begin
      tmo_cnt <= tmo_cnt_nxt;
      if (err_set) err_q <= 1'b1;
    end
  end
`endif

  always_comb begin
    state_nxt   = state;
    pc_ld       = 1'b0;
    ir_ld       = 1'b0;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    tmo_cnt_nxt = tmo_cnt;
    err_set     = 1'b0;
`endif
    case (state)
      IDLE: begin
        state_nxt = FETCH;
`ifdef FETCH_TIMEOUT_EN
        tmo_cnt_nxt = 5'd0;
`endif
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          // An ack in the final waiting cycle still wins over the timeout.
          ir_ld     = 1'b1;
          state_nxt = EXEC;
        end
`ifdef FETCH_TIMEOUT_EN
        else begin
          tmo_cnt_nxt = tmo_cnt + 5'd1;
          // The count reaches 16 on this edge: this was the 16th cycle without an ack.
          if (tmo_cnt == 5'd15) begin
            state_nxt = HALT;
            err_set   = 1'b1;
          end
        end
`endif
      end
      EXEC: begin
        instr_valid = 1'b1;
        if (exec_done) begin
          pc_ld     = 1'b1;
          state_nxt = FETCH;
`ifdef FETCH_TIMEOUT_EN
          tmo_cnt_nxt = 5'd0;
`endif
        end
      end
      HALT: begin
        state_nxt = HALT;
      end
    endcase
  end

  assign imem_addr = pc_q;
  assign PC        = pc_q;
  assign instr     = ir_q;
  assign Op        = ir_q[31:26];
  assign Funct     = ir_q[5:0];

`ifdef FETCH_TIMEOUT_EN
  assign fetch_err = err_q;
`else
  assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_seq.sv
module tb_instr_fetch_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  NPCOp = 2'b00;
  logic [25:0] IMM = 26'd0;
  logic        exec_done = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] instr;
  logic [5:0]  Op;
  logic [5:0]  Funct;
  logic        instr_valid;
  logic [31:0] PC;
  logic        fetch_err;

  int n_checks = 0;
  int n_fail   = 0;

  instr_fetch_seq dut (
    .clk(clk), .rst(rst), .NPCOp(NPCOp), .IMM(IMM), .exec_done(exec_done),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr(instr), .Op(Op), .Funct(Funct),
    .instr_valid(instr_valid), .PC(PC), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  // All driving and sampling happens on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  // Reference next-PC from the architectural rules.
  function automatic logic [31:0] npc_model(input logic [31:0] pc, input logic [1:0] op,
                                            input logic [25:0] imm);
    logic [31:0] p4;
    int          off;
    p4 = pc + 32'd4;
    if (op == 2'b01) begin
      off = $signed(imm[15:0]);
      return p4 + 32'(off * 4);
    end else if (op == 2'b10) begin
      return (p4 & 32'hF000_0000) | ({6'd0, imm} * 32'd4);
    end
    return p4;
  endfunction

  // Drivers only; the scenario tasks make the comparisons.
  task automatic restart_to_fetch();
    rst = 1'b1; imem_ack = 1'b0; exec_done = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic ack_now(input logic [31:0] data);
    imem_ack = 1'b1; imem_rdata = data;
    tick();
    imem_ack = 1'b0; imem_rdata = $urandom;
  endtask

  task automatic exec_now(input logic [1:0] op, input logic [25:0] imm);
    NPCOp = op; IMM = imm; exec_done = 1'b1;
    tick();
    exec_done = 1'b0; NPCOp = 2'($urandom); IMM = 26'($urandom);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    tick();
    rst = 1'b1; imem_ack = 1'b1; exec_done = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    n_checks++; if (PC !== 32'h0000_3000) begin n_fail++; $display("FAIL reset_pc: got %h want 00003000", PC); end
    n_checks++; if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", instr); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req); end
    n_checks++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", fetch_err); end
    exec_done = 1'b0;
    // Stale ack arriving during the single IDLE cycle must be ignored.
    rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hBAD0_0BAD;
    tick();
    n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL idle_one_cycle_req: got %b want 1", imem_req); end
    n_checks++; if (instr_valid !== 1'b0 || instr !== 32'h0) begin n_fail++; $display("FAIL stale_ack_idle: valid %b instr %h want 0/0", instr_valid, instr); end
    n_checks++; if (imem_addr !== 32'h0000_3000) begin n_fail++; $display("FAIL first_addr: got %h want 00003000", imem_addr); end
    // Ack in the same cycle as the first request.
    d = $urandom;
    ack_now(d);
    n_checks++; if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin n_fail++; $display("FAIL first_latency: valid %b req %b want 1/0", instr_valid, imem_req); end
    n_checks++; if (instr !== d) begin n_fail++; $display("FAIL first_instr: got %h want %h", instr, d); end
    n_checks++; if (Op !== d[31:26] || Funct !== d[5:0]) begin n_fail++; $display("FAIL op_funct: got %h/%h want %h/%h", Op, Funct, d[31:26], d[5:0]); end
  endtask

  // Entered in EXEC at PC=0x3000.
  task automatic test_plus4_branch();
    logic [31:0] d;
    d = instr;
    repeat (3) begin
      imem_ack = 1'b1;
      tick();
      n_checks++; if (instr_valid !== 1'b1 || instr !== d || PC !== 32'h0000_3000) begin n_fail++; $display("FAIL exec_hold: valid %b instr %h pc %h want 1/%h/00003000", instr_valid, instr, PC, d); end
    end
    imem_ack = 1'b0;
    exec_now(2'b00, 26'($urandom));
    n_checks++; if (imem_addr !== 32'h0000_3004 || imem_req !== 1'b1) begin n_fail++; $display("FAIL plus4: addr %h req %b want 00003004/1", imem_addr, imem_req); end
    ack_now($urandom);
    exec_now(2'b00, 26'd0);
    ack_now($urandom);
    n_checks++; if (PC !== 32'h0000_3008) begin n_fail++; $display("FAIL plus4_again: got %h want 00003008", PC); end
    exec_now(2'b01, 26'h3FF_FFFE);
    n_checks++; if (PC !== 32'h0000_3004 || imem_addr !== 32'h0000_3004) begin n_fail++; $display("FAIL branch_back: pc %h addr %h want 00003004", PC, imem_addr); end
  endtask

  task automatic test_jump();
    restart_to_fetch();
    ack_now($urandom);
    exec_now(2'b10, 26'h000_0C03);
    n_checks++; if (PC !== 32'h0000_300C) begin n_fail++; $display("FAIL jump: got %h want 0000300C", PC); end
  endtask

  // 0x3000 -> branch to 0 -> branch to 0xFFFFFFFC -> PLUS4 wraps to 0 -> op 11 acts as PLUS4.
  task automatic test_wrap();
    restart_to_fetch();
    ack_now($urandom);
    exec_now(2'b01, 26'h000_F3FF);
    n_checks++; if (PC !== 32'h0) begin n_fail++; $display("FAIL branch_to_zero: got %h want 0", PC); end
    ack_now($urandom);
    exec_now(2'b01, 26'h000_FFFE);
    n_checks++; if (PC !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL branch_wrap: got %h want FFFFFFFC", PC); end
    ack_now($urandom);
    exec_now(2'b00, 26'd0);
    n_checks++; if (PC !== 32'h0 || fetch_err !== 1'b0) begin n_fail++; $display("FAIL plus4_wrap: pc %h err %b want 0/0", PC, fetch_err); end
    ack_now($urandom);
    exec_now(2'b11, 26'h3FF_FFFF);
    n_checks++; if (PC !== 32'h4) begin n_fail++; $display("FAIL op11_plus4: got %h want 4", PC); end
  endtask

  task automatic test_ack_delay();
    logic [31:0] d;
    int req_cycles;
    restart_to_fetch();
    req_cycles = 0;
    for (int i = 0; i < 5; i++) begin
      if (imem_req === 1'b1 && imem_addr === 32'h0000_3000) req_cycles++;
      n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL delay_no_valid: cycle %0d got %b want 0", i, instr_valid); end
      exec_done = ~exec_done; NPCOp = 2'b10; IMM = 26'($urandom);
      tick();
    end
    exec_done = 1'b0;
    if (imem_req === 1'b1 && imem_addr === 32'h0000_3000) req_cycles++;
    n_checks++; if (req_cycles !== 6) begin n_fail++; $display("FAIL delay_req_stable: got %0d cycles want 6", req_cycles); end
    d = $urandom;
    ack_now(d);
    n_checks++; if (instr_valid !== 1'b1 || instr !== d || PC !== 32'h0000_3000) begin n_fail++; $display("FAIL delay_ack: valid %b instr %h pc %h want 1/%h/00003000", instr_valid, instr, PC, d); end
  endtask

  task automatic test_reset_mid();
    restart_to_fetch();
    tick();
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    tick();
    n_checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0) begin n_fail++; $display("FAIL reset_mid_fetch: req %b valid %b instr %h want 0/0/0", imem_req, instr_valid, instr); end
    rst = 1'b0;
    tick();
    n_checks++; if (imem_req !== 1'b1 || instr_valid !== 1'b0 || instr !== 32'h0) begin n_fail++; $display("FAIL stale_ack_after_reset: req %b valid %b instr %h want 1/0/0", imem_req, instr_valid, instr); end
    ack_now($urandom);
    rst = 1'b1; exec_done = 1'b1; NPCOp = 2'b10; IMM = 26'h3FF_FFFF;
    tick();
    rst = 1'b0; exec_done = 1'b0;
    n_checks++; if (PC !== 32'h0000_3000 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mid_exec: pc %h valid %b want 00003000/0", PC, instr_valid); end
  endtask

  task automatic test_random();
    logic [31:0] pc_m, d;
    logic [1:0]  op;
    logic [25:0] imm;
    restart_to_fetch();
    pc_m = 32'h0000_3000;
    for (int n = 0; n < 30; n++) begin
      for (int w = $urandom_range(0, 4); w > 0; w--) begin
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== pc_m || instr_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_fetch: req %b addr %h valid %b want 1/%h/0", imem_req, imem_addr, instr_valid, pc_m); end
        exec_done = 1'($urandom);
        tick();
      end
      exec_done = 1'b0;
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== pc_m) begin n_fail++; $display("FAIL rnd_addr: req %b addr %h want 1/%h", imem_req, imem_addr, pc_m); end
      d = $urandom;
      ack_now(d);
      for (int w = $urandom_range(0, 3); w > 0; w--) begin
        imem_ack = 1'($urandom);
        tick();
      end
      imem_ack = 1'b0;
      n_checks++; if (instr_valid !== 1'b1 || instr !== d || Op !== d[31:26] || Funct !== d[5:0] || PC !== pc_m) begin n_fail++; $display("FAIL rnd_exec: valid %b instr %h pc %h want 1/%h/%h", instr_valid, instr, PC, d, pc_m); end
      op = 2'($urandom); imm = 26'($urandom);
      exec_now(op, imm);
      pc_m = npc_model(pc_m, op, imm);
    end
    n_checks++; if (PC !== pc_m || fetch_err !== 1'b0) begin n_fail++; $display("FAIL rnd_final: pc %h err %b want %h/0", PC, fetch_err, pc_m); end
  endtask

`ifdef FETCH_TIMEOUT_EN
  task automatic test_timeout();
    int req_cycles;
    restart_to_fetch();
    req_cycles = 0;
    while (imem_req === 1'b1 && req_cycles < 40) begin
      req_cycles++;
      tick();
    end
    n_checks++; if (req_cycles !== 16) begin n_fail++; $display("FAIL timeout_cycles: got %0d want 16", req_cycles); end
    n_checks++; if (fetch_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL timeout_halt: err %b req %b valid %b want 1/0/0", fetch_err, imem_req, instr_valid); end
    for (int i = 0; i < 8; i++) begin
      imem_ack = 1'($urandom); exec_done = 1'($urandom);
      tick();
    end
    imem_ack = 1'b0; exec_done = 1'b0;
    n_checks++; if (fetch_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL halt_sticky: err %b req %b valid %b want 1/0/0", fetch_err, imem_req, instr_valid); end
    restart_to_fetch();
    n_checks++; if (fetch_err !== 1'b0 || imem_req !== 1'b1) begin n_fail++; $display("FAIL halt_reset: err %b req %b want 0/1", fetch_err, imem_req); end
    // Ack in the 16th waiting cycle wins, on both a fresh and a re-entered FETCH.
    for (int k = 0; k < 2; k++) begin
      repeat (15) tick();
      ack_now($urandom);
      n_checks++; if (instr_valid !== 1'b1 || fetch_err !== 1'b0) begin n_fail++; $display("FAIL ack_wins_%0d: valid %b err %b want 1/0", k, instr_valid, fetch_err); end
      exec_now(2'b00, 26'd0);
    end
  endtask
`else
  task automatic test_no_timeout();
    restart_to_fetch();
    repeat (40) tick();
    n_checks++; if (imem_req !== 1'b1 || fetch_err !== 1'b0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL no_timeout: req %b err %b valid %b want 1/0/0", imem_req, fetch_err, instr_valid); end
    ack_now($urandom);
    n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL late_ack: valid %b want 1", instr_valid); end
  endtask
`endif

  initial begin
    test_reset();
    test_plus4_branch();
    test_jump();
    test_wrap();
    test_ack_delay();
    test_reset_mid();
    test_random();
`ifdef FETCH_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_seq.md
INSTR_FETCH_SEQ -- requirements
Module: instr_fetch_seq

Interface
REQ-001 The block SHALL have one clock, clk, and one synchronous active-high reset, rst, sampled on the rising edge of clk.
REQ-002 Port list SHALL be as follows:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- NPCOp  in  2  next-PC select from ctrl: 00 PLUS4, 01 BRANCH, 10 JUMP, 11 treated as PLUS4.
- IMM  in  26  instruction immediate field from the core: [15:0] branch offset, [25:0] jump index.
- exec_done  in  1  core has finished the current instruction; NPCOp and IMM are valid.
- imem_req  out  1  instruction-memory read request.
- imem_addr  out  32  read address; equals PC.
- imem_ack  in  1  read complete; imem_rdata is valid.
- imem_rdata  in  32  instruction word.
- instr  out  32  instruction register (IR).
- Op  out  6  IR[31:26], drives ctrl.
- Funct  out  6  IR[5:0], drives ctrl.
- instr_valid  out  1  IR holds the instruction for the current PC.
- PC  out  32  current program counter.
- fetch_err  out  1  fetch timeout; sticky until reset.

Function
REQ-003 The FSM SHALL have the states IDLE, FETCH, EXEC and HALT; reset SHALL enter IDLE.
REQ-004 IDLE SHALL last exactly one cycle with imem_req=0, then go to FETCH.
REQ-005 In FETCH the block SHALL hold imem_req=1 and imem_addr=PC, and keep both stable until imem_ack is sampled high.
REQ-006 When imem_ack=1 in FETCH, the block SHALL capture imem_rdata into IR and enter EXEC on the same edge.
- Minimum latency from the first imem_req cycle to instr_valid is 1 cycle.
REQ-007 In EXEC the block SHALL hold instr_valid=1, imem_req=0, and keep IR and PC stable.
REQ-008 When exec_done=1 in EXEC, the block SHALL load PC with NPC and enter FETCH on the same edge.
REQ-009 NPC SHALL be computed as follows, with PC4 = PC+4 and all arithmetic modulo 2^32:
- PLUS4 / 11: PC4.
- BRANCH: PC4 + (sign-extended IMM[15:0] << 2).
- JUMP: {PC4[31:28], IMM[25:0], 2'b00}.
REQ-010 The block SHALL ignore imem_ack outside FETCH, including an ack for a request aborted by reset that arrives during IDLE.
REQ-011 The block SHALL ignore exec_done outside EXEC.
REQ-012 PC SHALL wrap from 0xFFFF_FFFC to 0x0000_0000 on PLUS4 without error.
REQ-013 Op and Funct SHALL be combinational slices of IR.
REQ-014 instr_valid SHALL be 0 in IDLE, FETCH and HALT.
REQ-015 HALT SHALL hold imem_req=0 and instr_valid=0, and SHALL be exited only by reset.

Reset
REQ-016 On rst=1 at a rising edge the block SHALL set:
- state=IDLE
- PC=0x0000_3000
- instr=0x0000_0000
- instr_valid=0
- imem_req=0
- fetch_err=0
- timeout counter=0
REQ-017 Reset SHALL take priority over all other inputs, including a coincident imem_ack or exec_done, and SHALL abort any fetch or execute in progress.

Configuration
REQ-018 With FETCH_TIMEOUT_EN defined, a 5-bit counter SHALL behave as follows:
- It clears on entry to FETCH.
- It increments each FETCH cycle in which imem_ack=0.
- When it reaches 16 with imem_ack=0, the block SHALL enter HALT and set fetch_err=1.
- An ack in the 16th waiting cycle SHALL win over the timeout.
REQ-019 Without FETCH_TIMEOUT_EN, no counter SHALL exist, fetch_err SHALL be tied to 0, HALT SHALL be unreachable, and FETCH SHALL wait indefinitely.

Verification
REQ-020 The bench SHALL cover the following directed scenarios:
- Reset release, imem_ack returned in the same cycle as the first request -> imem_addr=0x0000_3000, instr_valid=1 one cycle after the request, instr equals imem_rdata.
- PC=0x0000_3000, NPCOp=00, exec_done -> next imem_addr=0x0000_3004.
- PC=0x0000_3008, NPCOp=01, IMM[15:0]=0xFFFE, exec_done -> next PC=0x0000_3004.
- PC=0x0000_3000, NPCOp=10, IMM=0x0000C03, exec_done -> next PC=0x0000_300C.
- imem_ack delayed 5 cycles -> imem_req and imem_addr stable for 6 cycles, no instr_valid until the ack edge; exec_done pulsed during FETCH has no effect.
- With FETCH_TIMEOUT_EN, imem_ack never asserted -> fetch_err=1 and imem_req=0 after 16 wait cycles, held until rst; rst asserted mid-FETCH -> imem_req=0 next cycle, and a stale imem_ack during IDLE is ignored.
